// File: rtl/div_unit.sv
// Iterative restoring divider: 32/32 -> {remainder, quotient}, one quotient bit per cycle, MSB first.
// Optional macro DIV_ZERO_FAST_EN routes a zero divisor through a short ZERO state that returns 64'h0.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divider_i,
    input  logic        start_i,
    input  logic        cancel_i,
    output logic [63:0] result_o,
    output logic        success_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
`ifdef DIV_ZERO_FAST_EN
        ZERO = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        signed_r, sign_a, sign_b;
    logic [31:0] dvs, quo, rem;
    logic [31:0] a_mag, b_mag;
    logic [32:0] trial;
    logic        take;
    logic [31:0] quo_nxt, rem_nxt, quo_fix, rem_fix;

    always_comb begin
        a_mag = (signed_i && dividend_i[31]) ? (~dividend_i + 32'd1) : dividend_i;
        b_mag = (signed_i && divider_i[31])  ? (~divider_i + 32'd1)  : divider_i;

        // rem[31] set means the shifted remainder exceeds 2^32 and always covers the divisor
        trial = {rem, quo[31]} - {1'b0, dvs};
        take  = rem[31] | ~trial[32];
        if (take) begin
            rem_nxt = trial[31:0];
            quo_nxt = {quo[30:0], 1'b1};
        end else begin
            rem_nxt = {rem[30:0], quo[31]};
            quo_nxt = {quo[30:0], 1'b0};
        end

        quo_fix = (signed_r && (sign_a ^ sign_b)) ? (~quo_nxt + 32'd1) : quo_nxt;
        rem_fix = (signed_r && sign_a) ? (~rem_nxt + 32'd1) : rem_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i && !cancel_i) begin
`ifdef DIV_ZERO_FAST_EN
                    state_nxt = (divider_i == 32'd0) ? ZERO : BUSY;
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                if (cancel_i || !start_i)
                    state_nxt = IDLE;
                else if (cnt == 6'd31)
                    state_nxt = DONE;
            end
`ifdef DIV_ZERO_FAST_EN
            ZERO: state_nxt = cancel_i ? IDLE : DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Result and success are registered on the edge entering DONE so both are visible during DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            signed_r  <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            dvs       <= '0;
            quo       <= '0;
            rem       <= '0;
            result_o  <= '0;
            success_o <= 1'b0;
        end else begin
            success_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !cancel_i) begin
                        signed_r <= signed_i;
                        sign_a   <= dividend_i[31];
                        sign_b   <= divider_i[31];
                        quo      <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 6'd1;
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (state_nxt == DONE) begin
                        result_o  <= {rem_fix, quo_fix};
                        success_o <= 1'b1;
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                ZERO: begin
                    if (state_nxt == DONE) begin
                        result_o  <= '0;
                        success_o <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table plus hand sequences for cancel, withdraw and reset corners;
// a negedge monitor checks each success_o pulse against a queue of expected results and cycles.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divider_i;
    logic        start_i;
    logic        cancel_i;
    logic [63:0] result_o;
    logic        success_o;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    localparam int NFIX = 12;
    localparam int NVEC = 28;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif

    vec_t        vecs[NVEC];
    exp_t        exp_q[$];
    int          cyc;
    int          checks;
    int          errors;
    logic [63:0] last_exp;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (signed_i),
        .dividend_i(dividend_i),
        .divider_i (divider_i),
        .start_i   (start_i),
        .cancel_i  (cancel_i),
        .result_o  (result_o),
        .success_o (success_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chkint(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Scoreboard: every success pulse must match the head of the queue in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (success_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_success: got 1 at cycle %0d want 0", cyc);
            end else begin
                e = exp_q.pop_front();
                chk64("result", result_o, e.res);
                chkint("success_cycle", cyc, e.due);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_success: got none by cycle %0d want cycle %0d", cyc, e.due);
        end
    end

    task automatic run_div(input vec_t v);
        exp_t e;
        int   n;
        signed_i   = v.sg;
        dividend_i = v.a;
        divider_i  = v.b;
        cancel_i   = 1'b0;
        start_i    = 1'b1;
        e.res = v.res;
        e.due = cyc + v.lat;
        exp_q.push_back(e);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (success_o === 1'b1) break;
        end
        if (success_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no success in %0d cycles want success", n);
        end
        last_exp = v.res;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns want finish");
        $fatal(1);
    end

    initial begin
        logic signed [31:0] sa, sb;
        logic        [31:0] ua, ub, q, r;

        checks   = 0;
        errors   = 0;
        last_exp = 64'h0;
        rst        = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divider_i  = '0;
        start_i    = 1'b0;
        cancel_i   = 1'b0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
`ifdef DIV_ZERO_FAST_EN
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'h0,                 ZLAT};
        vecs[5]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          64'h0,                 ZLAT};
`else
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'h00000005_FFFFFFFF, ZLAT};
        vecs[5]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          64'hFFFFFFFB_00000001, ZLAT};
`endif
        vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33};
        vecs[9]  = '{1'b0, 32'd3,          32'hFFFFFFFF,   64'h00000003_00000000, 33};
        vecs[10] = '{1'b0, 32'h80000000,   32'h10,         64'h00000000_08000000, 33};
        vecs[11] = '{1'b0, 32'd12345678,   32'd1000,       {32'd678, 32'd12345},  33};

        for (int i = NFIX; i < NVEC; i++) begin
            vecs[i].sg = 1'($urandom_range(0, 1));
            ua = $urandom;
            ub = $urandom >> $urandom_range(0, 31);
            if (ub == 32'd0) ub = 32'd1;
            if (vecs[i].sg && ua == 32'h80000000 && ub == 32'hFFFFFFFF) ub = 32'd2;
            if (vecs[i].sg) begin
                sa = ua;
                sb = ub;
                q  = sa / sb;
                r  = sa % sb;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            vecs[i].a   = ua;
            vecs[i].b   = ub;
            vecs[i].res = {r, q};
            vecs[i].lat = 33;
        end

        #2;
        chk64("reset_result", result_o, 64'h0);
        chk64("reset_success", {63'h0, success_o}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Consecutive calls give back-to-back starts straight after each DONE.
        for (int i = 0; i < NVEC; i++) run_div(vecs[i]);
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Cancel pulse in BUSY cycle 10: no result, result_o keeps its last value.
        signed_i = 1'b0; dividend_i = 32'd1000; divider_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 cancel_i = 1'b1;
        @(posedge clk);
        #1 cancel_i = 1'b0; start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk64("cancel_hold", result_o, last_exp);
        run_div('{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33});
        start_i = 1'b0;
        @(posedge clk);
        #1;

        // Withdrawing start_i mid-BUSY acts as a cancel.
        signed_i = 1'b0; dividend_i = 32'd50; divider_i = 32'd5; start_i = 1'b1;
        repeat (6) @(posedge clk);
        #1 start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk64("withdraw_hold", result_o, last_exp);

        // start_i and cancel_i together in IDLE: cancel wins.
        signed_i = 1'b0; dividend_i = 32'd40; divider_i = 32'd4; start_i = 1'b1; cancel_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 start_i = 1'b0; cancel_i = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk64("start_cancel_hold", result_o, last_exp);

        // Asynchronous reset between edges during BUSY.
        signed_i = 1'b0; dividend_i = 32'd1000; divider_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk64("async_reset_result", result_o, 64'h0);
        chk64("async_reset_success", {63'h0, success_o}, 64'h0);
        start_i  = 1'b0;
        last_exp = 64'h0;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk64("post_reset_hold", result_o, last_exp);

        repeat (3) @(posedge clk);
        #1 chkint("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Port clk SHALL be an input, 1 bit wide: the rising-edge clock for all state.
REQ-003 Port rst SHALL be an input, 1 bit wide: asynchronous active-low reset (0 = reset).
REQ-004 Port signed_i SHALL be an input, 1 bit wide: 1 = signed two's-complement divide, 0 = unsigned.
REQ-005 Port dividend_i SHALL be an input, 32 bits wide: the dividend, sampled at start.
REQ-006 Port divider_i SHALL be an input, 32 bits wide: the divisor, sampled at start.
REQ-007 Port start_i SHALL be an input, 1 bit wide: request from the EX stage, held high until success_o is seen.
REQ-008 Port cancel_i SHALL be an input, 1 bit wide: pipeline flush that aborts any operation in progress.
REQ-009 Port result_o SHALL be an output, 64 bits wide: {HI = remainder, LO = quotient}, registered.
REQ-010 Port success_o SHALL be an output, 1 bit wide: result valid, high for exactly one cycle per completed divide.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, BUSY and DONE, plus ZERO when DIV_ZERO_FAST_EN is defined.
REQ-012 In IDLE with start_i=1 and cancel_i=0, the block SHALL latch signed_i, both operands and their sign bits at the clock edge, then go to BUSY with the iteration counter at 0.
REQ-013 While in BUSY, the block SHALL perform one restoring shift/subtract iteration on 32-bit magnitudes per cycle, giving one quotient bit per cycle, MSB first.
REQ-014 The iteration counter SHALL be 6 bits wide; BUSY SHALL go to DONE after the edge that completes iteration 31, for 32 BUSY cycles in total.
REQ-015 Latency: if start_i is sampled at the edge ending cycle T, success_o SHALL be 1 during cycle T+33 and 0 in every other cycle.
REQ-016 When signed_i=1, operands SHALL be converted to magnitudes before iterating; the quotient SHALL be negated when the dividend and divisor sign bits differ; the remainder SHALL be negated when the dividend is negative.
REQ-017 When signed_i=0, the block SHALL apply no sign handling.
REQ-018 Overflow case: signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with no exception signalled.
REQ-019 In DONE, result_o SHALL be written and success_o=1; the next state SHALL be IDLE unconditionally, and start_i SHALL be ignored in DONE.
REQ-020 result_o SHALL hold its last value until the next DONE; it is only meaningful while success_o=1.
REQ-021 If cancel_i=1 in any state, the next state SHALL be IDLE, success_o SHALL be 0 in the following cycle, and result_o SHALL be unchanged.
REQ-022 If start_i=0 while in BUSY (operation withdrawn), the block SHALL treat it as a cancel.
REQ-023 If start_i and cancel_i are both 1 in IDLE, cancel_i SHALL win and the block SHALL stay in IDLE.
REQ-024 After DONE, a new divide SHALL begin only once start_i is 1 in IDLE; a back-to-back request SHALL start in the cycle after DONE.

Reset
REQ-025 While rst=0, regardless of clk, the state SHALL be IDLE, the counter 0, result_o 64'h0 and success_o 0, with all operand registers cleared.
REQ-026 A reset asserted during BUSY SHALL abort the operation; no success_o SHALL follow the release of reset.

Configuration
REQ-027 With DIV_ZERO_FAST_EN defined, a zero divisor sampled at start SHALL route IDLE -> ZERO -> DONE, giving result_o=64'h0 with success_o in cycle T+2.
REQ-028 Without DIV_ZERO_FAST_EN, a zero divisor SHALL run the full 32 iterations and give quotient magnitude 0xFFFFFFFF and remainder magnitude |dividend|, with the sign rules of REQ-016 applied; success_o SHALL follow at T+33.

Verification
REQ-029 Unsigned 100/7: start at T -> success_o=1 only at T+33, with result_o=64'h00000002_0000000E.
REQ-030 Signed 0xFFFFFFF9/2 (-7/2) -> result_o=64'hFFFFFFFF_FFFFFFFD (remainder -1, quotient -3).
REQ-031 Signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000; unsigned 0xFFFFFFFF/1 -> result_o=64'h00000000_FFFFFFFF.
REQ-032 Unsigned 5/0 -> with the macro, result_o=64'h0 with success_o at T+2; without it, result_o=64'h00000005_FFFFFFFF at T+33.
REQ-033 Start 1000/3, pulse cancel_i in BUSY cycle 10 -> no success_o; then start 9/3 -> result_o=64'h00000000_00000003 at the new T+33.
REQ-034 Drive rst=0 mid-BUSY between clock edges -> outputs clear immediately; after release with start_i=0, success_o stays 0 for 40 cycles.
